button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
- Turns the debounced level signals of NUM_BTN buttons into discrete press, auto-repeat and release events.
- Delivers the events to the game logic over a single valid/ready channel.
- Sits downstream of the per-button debouncers and upstream of the game FSM, e.g. flap and menu navigation.
- Contains one press/hold FSM per button, a one-slot pending buffer per button, and a round-robin arbiter feeding one output register.

Parameters:
- NUM_BTN, 4: number of buttons; must be at least 2.
- HOLD_CYCLES, 50000000: cycles a button must be held after the press event before the first repeat event; must be at least 2.
- REPEAT_CYCLES, 10000000: cycles between successive repeat events; must be at least 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  event generation enable.
- btn_level  in  NUM_BTN  debounced button levels, synchronous to clk.
- evt_valid  out  1  output event valid.
- evt_ready  in  1  consumer accepts the event.
- evt_id  out  IDW=max(1,$clog2(NUM_BTN))  index of the button that produced the event.
- evt_type  out  2  event type: 0 PRESS, 1 REPEAT, 2 RELEASE.
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async, resetn=0) clears everything:
  - evt_valid=0, evt_id=0, evt_type=0, ovf=0.
  - All FSMs go to IDLE; all counters, pending flags and prev-level registers are 0.
  - The round-robin pointer is 0.
- Reset mid-operation discards all pending and in-flight events.
- Edge detection per button i: prev[i] <= btn_level[i] every cycle.
  - Rise = btn_level[i] & ~prev[i]; fall = ~btn_level[i] & prev[i].
- Per-button FSM states: IDLE, HELD, REPEAT. Per-button counter cnt.
  - IDLE, en=1 and rise: emit PRESS, cnt<=0, go to HELD.
  - HELD, level high: cnt++. When cnt==HOLD_CYCLES-1: emit REPEAT, cnt<=0, go to REPEAT.
  - REPEAT, level high: cnt++. When cnt==REPEAT_CYCLES-1: emit REPEAT, cnt<=0.
  - HELD or REPEAT, fall: emit RELEASE, go to IDLE. Fall takes priority over counter expiry in the same cycle.
  - en=0: all FSMs forced to IDLE with no events. Pending slots and the output register are kept and still drain.
  - Re-enabling en while a button is already held produces no PRESS. A new rise is required.
- Counter width: $clog2(max(HOLD_CYCLES,REPEAT_CYCLES))+1. The counter never wraps.
- Pending slot per button (pend_v, pend_type):
  - An emit at edge t sets pend_v and pend_type at edge t.
  - If pend_v is already 1 and is not being granted that cycle, the new event is dropped and ovf <= 1. The old event is kept.
  - If the slot is granted in the same cycle as a new emit, the new event is stored: grant clears and the new emit sets.
- Arbiter and output register:
  - load = ~evt_valid | evt_ready.
  - When load and any pend_v is set, grant the first pending index at or after rr_ptr, cyclically.
  - On grant: evt_valid<=1, evt_id<=index, evt_type<=pend_type, clear that pend_v, rr_ptr <= index+1 mod NUM_BTN.
  - When load and nothing is pending: evt_valid<=0.
  - evt_id and evt_type hold stable while evt_valid & ~evt_ready.
  - Throughput is one event per cycle under continuous ready.
- Latency: a rise sampled at edge t gives evt_valid=1 after edge t+1, provided the output is free.
- ovf_clr: ovf<=0. A new drop in the same cycle as ovf_clr wins, so ovf ends at 1.

Decomposition:
- Package btn_evt_pkg: event type constants EVT_PRESS=2'd0, EVT_REPEAT=2'd1, EVT_RELEASE=2'd2, and the FSM state encodings.
- Sub-module btn_evt_fsm: one per button, generated.
  - Contains the edge detector, the FSM and the counter.
  - Outputs a 1-cycle emit strobe and the emit type.
- Pending slots, arbiter and output register live in the top module.

Test Plan:
All scenarios use NUM_BTN=4, HOLD_CYCLES=10, REPEAT_CYCLES=4, en=1 and evt_ready=1 unless stated.
- Single tap: btn_level[2] rises at edge 5 and falls at edge 8.
  - Expect evt_valid high after edge 6 with id=2, type=PRESS.
  - Expect id=2, type=RELEASE after edge 9.
  - No REPEAT.
- Hold: btn 1 held for 30 cycles.
  - Expect PRESS, then REPEAT 10 cycles after the press emit, then REPEAT every 4 cycles.
  - Expect RELEASE on fall.
  - Check a fall coinciding with cnt==3 in REPEAT gives RELEASE only.
- Simultaneous: all 4 buttons rise at the same edge.
  - Expect PRESS ids 0,1,2,3 on 4 consecutive cycles.
  - Then a simultaneous release gives RELEASE ids in rotating order starting at rr_ptr=0.
- Backpressure and overflow: evt_ready=0, btn 0 press then release.
  - The PRESS is held stable on the output.
  - The RELEASE sits pending.
  - A second press/release on btn 0 sets ovf=1.
  - After evt_ready=1: PRESS then RELEASE are delivered; ovf stays 1 until ovf_clr.
- Enable gating: hold btn 3, pulse en=0 for 3 cycles, then en=1 while still held.
  - No RELEASE and no REPEAT while en=0 or after re-enable.
  - A later fall/rise produces a fresh PRESS.
- Async reset: assert resetn=0 mid-stream with evt_valid=1 and pending events.
  - evt_valid=0 and ovf=0 immediately, without waiting for a clock edge.
  - After release of reset, a held button produces no event until a new rise.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the button event controller.
//   - Event type codes carried on evt_type.
//   - Per-button press/hold FSM state encoding.
//   - Small constant helper used to size the hold/repeat counters.
// ---------------------------------------------------------------------------
package btn_evt_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_REPEAT  = 2'd1;
   localparam logic [1:0] EVT_RELEASE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_evt_fsm.sv
// ---------------------------------------------------------------------------
// btn_evt_fsm
// Press/hold/repeat tracker for a single debounced button.
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   en         in   event generation enable; low forces IDLE silently
//   level      in   debounced button level, synchronous to clk
//   emit       out  one-cycle strobe: an event is produced at this edge
//   emit_type  out  type of the event being emitted (PRESS/REPEAT/RELEASE)
// ---------------------------------------------------------------------------
module btn_evt_fsm
   import btn_evt_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       en,
   input  logic       level,
   output logic       emit,
   output logic [1:0] emit_type
);

   localparam int CNTW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES)) + 1;
   localparam logic [CNTW-1:0] HOLD_LAST   = CNTW'(HOLD_CYCLES - 1);
   localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(REPEAT_CYCLES - 1);

   btn_state_t      state;
   btn_state_t      state_next;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_next;
   logic            prev;
   logic            rise;
   logic            fall;

   assign rise = level & ~prev;
   assign fall = ~level & prev;

   // State, counter and previous-level registers. prev tracks the level
   // every cycle, even while disabled, so re-enabling over a held button
   // does not look like a fresh rise.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= '0;
         prev  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         prev  <= level;
      end
   end

   // Next-state and counter logic. A fall is checked before counter expiry
   // so releasing on the expiry cycle yields a RELEASE and nothing else.
   // The counter restarts at every expiry, so it never wraps.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (!en) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state_next = ST_HELD;
                  cnt_next   = '0;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  state_next = ST_IDLE;
               end else if (level) begin
                  if (cnt == HOLD_LAST) begin
                     state_next = ST_REPEAT;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end
            end
            ST_REPEAT: begin
               if (fall) begin
                  state_next = ST_IDLE;
               end else if (level) begin
                  if (cnt == REPEAT_LAST) begin
                     cnt_next = '0;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Event strobe, decoded from the same conditions as the transitions.
   always_comb begin
      emit      = 1'b0;
      emit_type = EVT_PRESS;
      if (en) begin
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  emit      = 1'b1;
                  emit_type = EVT_PRESS;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  emit      = 1'b1;
                  emit_type = EVT_RELEASE;
               end else if (level && (cnt == HOLD_LAST)) begin
                  emit      = 1'b1;
                  emit_type = EVT_REPEAT;
               end
            end
            ST_REPEAT: begin
               if (fall) begin
                  emit      = 1'b1;
                  emit_type = EVT_RELEASE;
               end else if (level && (cnt == REPEAT_LAST)) begin
                  emit      = 1'b1;
                  emit_type = EVT_REPEAT;
               end
            end
            default: begin
               emit      = 1'b0;
               emit_type = EVT_PRESS;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
// Converts NUM_BTN debounced button levels into PRESS / REPEAT / RELEASE
// events and delivers them over one valid/ready channel.
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   en         in   event generation enable
//   btn_level  in   debounced button levels, synchronous to clk
//   evt_valid  out  output event valid
//   evt_ready  in   consumer accepts the event
//   evt_id     out  index of the button that produced the event
//   evt_type   out  event type (0 PRESS, 1 REPEAT, 2 RELEASE)
//   ovf        out  sticky: an event was dropped
//   ovf_clr    in   clears ovf (a simultaneous drop wins)
// ---------------------------------------------------------------------------
module button_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter int NUM_BTN       = 4,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   localparam int IDW          = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic [NUM_BTN-1:0] btn_level,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDW-1:0]     evt_id,
   output logic [1:0]         evt_type,
   output logic               ovf,
   input  logic               ovf_clr
);

   localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_BTN - 1);

   logic [NUM_BTN-1:0] emit;
   logic [1:0]         emit_type [NUM_BTN];
   logic [NUM_BTN-1:0] pend_v;
   logic [1:0]         pend_type [NUM_BTN];
   logic [NUM_BTN-1:0] grant_vec;
   logic [NUM_BTN-1:0] drop_vec;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_idx;
   logic               grant_any;
   logic               load;

   assign load     = ~evt_valid | evt_ready;
   assign drop_vec = emit & pend_v & ~grant_vec;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_evt_fsm #(
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_fsm (
         .clk       (clk),
         .resetn    (resetn),
         .en        (en),
         .level     (btn_level[g]),
         .emit      (emit[g]),
         .emit_type (emit_type[g])
      );

      // One-slot pending buffer. A grant frees the slot in the same cycle,
      // so an emit coinciding with its own grant is stored, not dropped.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            pend_v[g]    <= 1'b0;
            pend_type[g] <= EVT_PRESS;
         end else if (emit[g] && (!pend_v[g] || grant_vec[g])) begin
            pend_v[g]    <= 1'b1;
            pend_type[g] <= emit_type[g];
         end else if (grant_vec[g]) begin
            pend_v[g]    <= 1'b0;
         end
      end
   end

   // Round-robin search: first pending slot at or after rr_ptr, wrapping.
   always_comb begin
      int             cand;
      logic [IDW-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      if (load) begin
         for (int k = 0; k < NUM_BTN; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_BTN;
            cand_idx = IDW'(cand);
            if (!grant_any && pend_v[cand_idx]) begin
               grant_any = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
      if (grant_any) begin
         grant_vec[grant_idx] = 1'b1;
      end
   end

   // Output register. id/type only change on a grant, so they stay stable
   // under backpressure and keep the last value once the channel idles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_type  <= EVT_PRESS;
         rr_ptr    <= '0;
      end else if (load) begin
         if (grant_any) begin
            evt_valid <= 1'b1;
            evt_id    <= grant_idx;
            evt_type  <= pend_type[grant_idx];
            rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

   // Sticky overflow flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf <= 1'b0;
      end else if (|drop_vec) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_event_ctrl
// Bench for button_event_ctrl with NUM_BTN=4, HOLD_CYCLES=10, REPEAT_CYCLES=4.
// Inputs change on the falling edge; outputs are compared on the falling
// edge against constant vectors and against a behavioural model that tracks
// each button as "active since press, age N cycles".
// ---------------------------------------------------------------------------
module tb_button_event_ctrl;

   localparam int NB   = 4;
   localparam int HOLD = 10;
   localparam int REP  = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          en;
   logic [NB-1:0] btn_level;
   logic          evt_valid;
   logic          evt_ready;
   logic [1:0]    evt_id;
   logic [1:0]    evt_type;
   logic          ovf;
   logic          ovf_clr;

   button_event_ctrl #(
      .NUM_BTN       (NB),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_type  (evt_type),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int n_press;
   int n_repeat;
   int n_release;

   // Reference model state.
   bit m_active [NB];
   int m_age    [NB];
   bit m_prev   [NB];
   bit m_pv     [NB];
   int m_pt     [NB];
   int m_rr;
   bit m_valid;
   int m_id;
   int m_type;
   bit m_ovf;

   typedef struct {
      bit          rst;
      logic [3:0]  btn;
      bit          en;
      bit          rdy;
      bit          clr;
      bit          exp_v;
      int          exp_id;
      int          exp_t;
      bit          exp_o;
   } vec_t;

   vec_t vecs[$];

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_active[i] = 0;
         m_age[i]    = 0;
         m_prev[i]   = 0;
         m_pv[i]     = 0;
         m_pt[i]     = 0;
      end
      m_rr    = 0;
      m_valid = 0;
      m_id    = 0;
      m_type  = 0;
      m_ovf   = 0;
   endtask

   // One clock edge of the behavioural model, using the inputs as they
   // stood just before the edge.
   task automatic model_step();
      int ev [NB];
      int g;
      bit drop;
      bit rise;
      bit fall;
      bit lvl;
      g    = -1;
      drop = 0;
      for (int i = 0; i < NB; i++) begin
         lvl   = btn_level[i];
         rise  = lvl && !m_prev[i];
         fall  = !lvl && m_prev[i];
         ev[i] = -1;
         if (!en) begin
            m_active[i] = 0;
         end else if (!m_active[i]) begin
            if (rise) begin
               ev[i] = 0; m_active[i] = 1; m_age[i] = 0;
            end
         end else if (fall) begin
            ev[i] = 2; m_active[i] = 0;
         end else if (lvl) begin
            m_age[i]++;
            if (m_age[i] >= HOLD && ((m_age[i] - HOLD) % REP) == 0) ev[i] = 1;
         end
         m_prev[i] = lvl;
      end
      if (!m_valid || evt_ready) begin
         for (int k = 0; k < NB; k++) begin
            if (g < 0 && m_pv[(m_rr + k) % NB]) g = (m_rr + k) % NB;
         end
         if (g >= 0) begin
            m_valid = 1; m_id = g; m_type = m_pt[g]; m_rr = (g + 1) % NB;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < NB; i++) begin
         if (i == g) m_pv[i] = 0;
         if (ev[i] >= 0) begin
            if (m_pv[i]) drop = 1;
            else begin
               m_pv[i] = 1; m_pt[i] = ev[i];
            end
         end
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
   endtask

   task automatic checkOutput();
      check_eq("model_valid", evt_valid, m_valid);
      check_eq("model_id", evt_id, m_id);
      check_eq("model_type", evt_type, m_type);
      check_eq("model_ovf", ovf, m_ovf);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!resetn) model_reset();
      else model_step();
      @(negedge clk);
      checkOutput();
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
         case (evt_type)
            2'd0:    n_press++;
            2'd1:    n_repeat++;
            default: n_release++;
         endcase
      end
   endtask

   task automatic applyStimulus(input bit rst, input logic [3:0] btn, input bit e,
                                input bit rdy, input bit clr);
      resetn    = !rst;
      if (rst) model_reset();
      btn_level = btn;
      en        = e;
      evt_ready = rdy;
      ovf_clr   = clr;
      tick();
   endtask

   task automatic clear_counts();
      n_press = 0; n_repeat = 0; n_release = 0;
   endtask

   initial begin
      resetn    = 1'b0;
      en        = 1'b1;
      btn_level = '0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;
      model_reset();
      clear_counts();
      @(negedge clk);

      // ---- Table: single tap on button 2, then simultaneous press/release
      //      rst  btn      en rdy clr  v  id t  o
      vecs.push_back('{1, 4'b0000, 1, 1, 0, 0, 0, 0, 0});
      for (int i = 0; i < 4; i++) vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 4'b0100, 1, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 4'b0100, 1, 1, 0, 1, 2, 0, 0});
      vecs.push_back('{0, 4'b0100, 1, 1, 0, 0, 2, 0, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 2, 0, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 1, 2, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 2, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 2, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 2, 2, 0});
      vecs.push_back('{1, 4'b0000, 1, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 1, 0, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 1, 1, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 1, 2, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 1, 3, 0, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 0, 0, 3, 0, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 3, 0, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 1, 0, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 1, 1, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 1, 2, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 1, 3, 2, 0});
      vecs.push_back('{0, 4'b0000, 1, 1, 0, 0, 3, 2, 0});

      foreach (vecs[r]) begin
         applyStimulus(vecs[r].rst, vecs[r].btn, vecs[r].en, vecs[r].rdy, vecs[r].clr);
         check_eq($sformatf("tbl%0d_valid", r), evt_valid, vecs[r].exp_v);
         check_eq($sformatf("tbl%0d_id", r), evt_id, vecs[r].exp_id);
         check_eq($sformatf("tbl%0d_type", r), evt_type, vecs[r].exp_t);
         check_eq($sformatf("tbl%0d_ovf", r), ovf, vecs[r].exp_o);
      end

      // ---- Hold button 1 for 30 cycles; the release lands on a repeat expiry
      applyStimulus(1, 4'b0000, 1, 1, 0);
      clear_counts();
      for (int i = 0; i < 30; i++) applyStimulus(0, 4'b0010, 1, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0000, 1, 1, 0);
      check_eq("hold_press", n_press, 1);
      check_eq("hold_repeat", n_repeat, 5);
      check_eq("hold_release", n_release, 1);

      // ---- Backpressure and overflow on button 0
      applyStimulus(1, 4'b0000, 1, 1, 0);
      applyStimulus(0, 4'b0001, 1, 0, 0);
      applyStimulus(0, 4'b0001, 1, 0, 0);
      applyStimulus(0, 4'b0000, 1, 0, 0);
      applyStimulus(0, 4'b0000, 1, 0, 0);
      check_eq("bp_ovf_before", ovf, 0);
      applyStimulus(0, 4'b0001, 1, 0, 0);
      applyStimulus(0, 4'b0001, 1, 0, 0);
      applyStimulus(0, 4'b0000, 1, 0, 0);
      applyStimulus(0, 4'b0000, 1, 0, 0);
      check_eq("bp_hold_valid", evt_valid, 1);
      check_eq("bp_hold_type", evt_type, 0);
      check_eq("bp_ovf_set", ovf, 1);
      applyStimulus(0, 4'b0000, 1, 1, 0);
      check_eq("bp_rel_valid", evt_valid, 1);
      check_eq("bp_rel_type", evt_type, 2);
      applyStimulus(0, 4'b0000, 1, 1, 0);
      check_eq("bp_idle_valid", evt_valid, 0);
      check_eq("bp_ovf_sticky", ovf, 1);
      applyStimulus(0, 4'b0000, 1, 1, 1);
      check_eq("bp_ovf_clr", ovf, 0);

      // ---- Enable gating while button 3 is held
      applyStimulus(1, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 4'b1000, 1, 1, 0);
      check_eq("en_first_press", n_press > 0, 1);
      clear_counts();
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'b1000, 0, 1, 0);
      for (int i = 0; i < 20; i++) applyStimulus(0, 4'b1000, 1, 1, 0);
      check_eq("en_gated_events", n_press + n_repeat + n_release, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'b1000, 1, 1, 0);
      check_eq("en_fresh_press", n_press, 1);
      check_eq("en_no_release", n_release, 0);

      // ---- Async reset with an event in flight, pending slots and ovf set
      applyStimulus(1, 4'b0000, 1, 1, 0);
      applyStimulus(0, 4'b1111, 1, 0, 0);
      applyStimulus(0, 4'b1111, 1, 0, 0);
      applyStimulus(0, 4'b0000, 1, 0, 0);
      applyStimulus(0, 4'b1111, 1, 0, 0);
      check_eq("rst_pre_valid", evt_valid, 1);
      check_eq("rst_pre_ovf", ovf, 1);
      #1;
      resetn = 1'b0;
      model_reset();
      #1;
      check_eq("rst_async_valid", evt_valid, 0);
      check_eq("rst_async_ovf", ovf, 0);
      check_eq("rst_async_id", evt_id, 0);
      tick();
      tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) applyStimulus(0, 4'b1111, 0, 1, 0);
      clear_counts();
      for (int i = 0; i < 10; i++) applyStimulus(0, 4'b1111, 1, 1, 0);
      check_eq("rst_held_silent", n_press + n_repeat + n_release, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 4'b1111, 1, 1, 0);
      check_eq("rst_new_press", n_press, 4);

      // ---- Randomised traffic against the model
      applyStimulus(1, 4'b0000, 1, 1, 0);
      begin
         logic [3:0] b;
         b = 4'b0000;
         for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
               if ($urandom_range(0, 15) == 0) b[i] = ~b[i];
            end
            applyStimulus(0, b, $urandom_range(0, 63) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
